ntr_cmd_leds: RTL
=================

# ntr_cmd_leds

Parametrised command executor behind the NTR cartridge-bus capture block: consumes each captured 64-bit command when the capture block raises `ready`, decodes it, and drives CHANNELS indicator outputs with set/clear/toggle/write and per-channel blink modes. It replaces the single-LED `0xFF` handler in the FPGA top level and adds accepted/rejected command counters for debug.

## Interface
- CHANNELS, 4: number of driven outputs, 1..16
- OPCODE, 8'hFF: command byte 0 value addressed to this block
- PRESCALE, 16: blink prescaler width; phase step every 2^PRESCALE clk cycles
- CNT_W, 8: width of both counters
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- command  in  64  captured command, byte k = command[8k+7:8k]; stable while ready high
- ready  in  1  level from capture block, synchronous to clk; high = command valid
- leds  out  CHANNELS  displayed outputs
- busy  out  1  high in EXEC and HOLD
- cmd_cnt  out  CNT_W  accepted commands, wraps
- err_cnt  out  CNT_W  rejected commands, saturates at all-ones

## Operation
- Command fields: byte0 opcode; byte1 mode; {byte3,byte2} channel mask M (bits ≥ CHANNELS ignored); {byte5,byte4} argument A; bytes 6-7 reserved, ignored.
- Modes: 0x00 WRITE level = (level & ~M) | (A & M); 0x01 SET level |= M; 0x02 CLEAR level &= ~M; 0x03 TOGGLE level ^= M; 0x04 BLINK blink_en = (blink_en & ~M) | (A[0] ? M : 0) and period = A[15:1] if A[0].
- byte0 ≠ OPCODE or mode > 0x04: rejected; err_cnt increments (saturating), no other state changes.
- Accepted: cmd_cnt increments (wrap), register update as above.
- Display: leds[i] = level[i] & (~blink_en[i] | phase).
- Blink timer: prescaler free-runs; on each prescaler wrap a period counter increments; when it reaches period it clears and phase toggles. period = 0: phase held at 1 (solid). Writing period resets period counter and sets phase = 1.
- FSM: IDLE -> EXEC when ready high; EXEC -> HOLD unconditionally (update applied on this edge); HOLD -> IDLE when ready low, else stay. One command per ready high-pulse, regardless of pulse length.

## Timing
- Reset (async, rst_n low): state IDLE, level 0, blink_en 0, period 0, phase 1, prescaler and counters 0; leds 0, busy 0, cmd_cnt 0, err_cnt 0.
- ready first sampled high at edge N: EXEC after N, update visible after edge N+1; busy high after N.
- ready sampled low in HOLD at edge M: IDLE after M; a ready high at edge M+1 starts the next command.
- ready pulse of exactly one cycle is still executed (capture at EXEC uses the command held that cycle; command must remain stable through edge N+1).
- ready falling during EXEC: command still executes, HOLD exits on the following edge.
- Blink phase change and command update on the same edge: command result applies, then the display uses new level/blink_en with current phase.
- rst_n asserted mid-command: immediate return to reset values; a still-high ready after deassert is treated as a new command.

## Structure
- Package ntr_pkg: OPCODE default, mode constants MODE_WRITE/SET/CLEAR/TOGGLE/BLINK, FSM state encoding (IDLE, EXEC, HOLD), field index constants for command bytes.
- Sub-module ntr_blink_timer: prescaler, period counter, phase output, period load input.
- Top: FSM, decoder, level/blink_en registers, counters.

## Test plan
- Reset then command {byte0 FF, byte1 01, M 0x0005}, ready held 10 cycles -> leds 4'b0101 two edges after ready, cmd_cnt 1, busy low one edge after ready drops.
- WRITE M 0x000F A 0x000A then TOGGLE M 0x0003 -> leds 1010 then 1001; cmd_cnt 2.
- byte0 0x12, then byte0 FF mode 0x07 -> leds unchanged, err_cnt 2, cmd_cnt unchanged; 300 rejected commands with CNT_W 8 -> err_cnt 0xFF.
- PRESCALE 2, SET M 1, BLINK M 1 A 0x0007 (period 3) -> leds[0] toggles every 12 cycles; BLINK A 0x0000 -> leds[0] solid 1.
- One-cycle ready pulse -> executed exactly once; ready held 100 cycles -> cmd_cnt +1 only.
- rst_n low during EXEC -> all outputs 0 asynchronously; release with ready high -> command executes once.

Source files
------------

// File: rtl/ntr_pkg.sv
// Shared definitions for the NTR command LED executor.
// Contents: default opcode, mode byte values, FSM state type,
// bit positions of the command fields, and a mode validity helper.
package ntr_pkg;

  localparam logic [7:0] OPCODE_DEFAULT = 8'hFF;

  localparam logic [7:0] MODE_WRITE  = 8'h00;
  localparam logic [7:0] MODE_SET    = 8'h01;
  localparam logic [7:0] MODE_CLEAR  = 8'h02;
  localparam logic [7:0] MODE_TOGGLE = 8'h03;
  localparam logic [7:0] MODE_BLINK  = 8'h04;

  // Bit offsets of the fields inside the 64-bit command word.
  localparam int unsigned OPC_LSB  = 0;   // byte0
  localparam int unsigned MODE_LSB = 8;   // byte1
  localparam int unsigned MASK_LSB = 16;  // {byte3,byte2}
  localparam int unsigned ARG_LSB  = 32;  // {byte5,byte4}
  localparam int unsigned RSVD_LSB = 48;  // bytes 6-7, ignored

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic mode_valid(input logic [7:0] mode);
    return (mode <= MODE_BLINK);
  endfunction

endpackage

// File: rtl/ntr_cmd_leds_if.sv
// Command hand-off from the cartridge-bus capture block.
//   command : captured 64-bit command, stable while ready is high
//   ready   : level, high while command is valid
// master = capture block side, slave = command executor side.
interface ntr_cmd_leds_if;
  logic [63:0] command;
  logic        ready;

  modport master (output command, output ready);
  modport slave  (input  command, input  ready);
endinterface

// File: rtl/ntr_blink_timer.sv
// Blink phase generator.
//   clk, rst_n   : clock, async active-low reset
//   load         : load a new period (restarts period count, phase=1)
//   load_period  : period in prescaler wraps, 0 = solid (phase held 1)
//   phase        : blink phase, 1 = on
module ntr_blink_timer #(
  parameter int unsigned PRESCALE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [14:0] load_period,
  output logic        phase
);

  localparam logic [PRESCALE-1:0] PRESC_ONE = 1;

  logic [PRESCALE-1:0] presc_q;
  logic [14:0]         period_q;
  logic [14:0]         pcnt_q;
  logic                phase_q;
  logic                tick;

  assign tick  = &presc_q;
  assign phase = phase_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= '0;
      period_q <= '0;
      pcnt_q   <= '0;
      phase_q  <= 1'b1;
    end else begin
      presc_q <= presc_q + PRESC_ONE;
      // A load on the same edge as a wrap takes priority: the new
      // period always starts from a clean count with phase on.
      if (load) begin
        period_q <= load_period;
        pcnt_q   <= '0;
        phase_q  <= 1'b1;
      end else if (period_q == '0) begin
        pcnt_q  <= '0;
        phase_q <= 1'b1;
      end else if (tick) begin
        if (pcnt_q + 15'd1 == period_q) begin
          pcnt_q  <= '0;
          phase_q <= ~phase_q;
        end else begin
          pcnt_q <= pcnt_q + 15'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ntr_cmd_leds.sv
// Command executor driving CHANNELS indicator outputs.
//   clk, rst_n : clock, async active-low reset
//   bus        : command/ready from the capture block (slave side)
//   leds       : displayed outputs (level gated by blink phase)
//   busy       : high while a command is in EXEC or HOLD
//   cmd_cnt    : accepted commands, wraps
//   err_cnt    : rejected commands, saturates at all-ones
module ntr_cmd_leds
  import ntr_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter logic [7:0]  OPCODE   = OPCODE_DEFAULT,
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  ntr_cmd_leds_if.slave       bus,
  output logic [CHANNELS-1:0] leds,
  output logic                busy,
  output logic [CNT_W-1:0]    cmd_cnt,
  output logic [CNT_W-1:0]    err_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t state_q, state_d;
  logic   exec_en;

  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] blink_q, blink_d;
  logic                accept, reject, period_load;
  logic                phase;

  logic [7:0]  f_opc, f_mode;
  logic [15:0] f_mask, f_arg;
  logic [CHANNELS-1:0] m, a;
  logic        unused_bits;

  assign f_opc  = bus.command[OPC_LSB  +: 8];
  assign f_mode = bus.command[MODE_LSB +: 8];
  assign f_mask = bus.command[MASK_LSB +: 16];
  assign f_arg  = bus.command[ARG_LSB  +: 16];
  assign m      = f_mask[CHANNELS-1:0];
  assign a      = f_arg[CHANNELS-1:0];
  // Reserved bytes and mask/argument bits above CHANNELS are ignored.
  assign unused_bits = ^{bus.command[RSVD_LSB +: 16], f_mask, f_arg};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: one execution per ready pulse, however long it is held.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.ready) state_d = EXEC;
      EXEC:    state_d = HOLD;
      HOLD:    if (!bus.ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy    = (state_q != IDLE);
    exec_en = (state_q == EXEC);
  end

  // Command decode and register update values
  always_comb begin
    level_d     = level_q;
    blink_d     = blink_q;
    accept      = 1'b0;
    reject      = 1'b0;
    period_load = 1'b0;
    if (exec_en) begin
      if (f_opc == OPCODE && mode_valid(f_mode)) begin
        accept = 1'b1;
        unique case (f_mode)
          MODE_WRITE:  level_d = (level_q & ~m) | (a & m);
          MODE_SET:    level_d = level_q | m;
          MODE_CLEAR:  level_d = level_q & ~m;
          MODE_TOGGLE: level_d = level_q ^ m;
          MODE_BLINK: begin
            blink_d     = (blink_q & ~m) | (f_arg[0] ? m : '0);
            period_load = f_arg[0];
          end
          default: ;
        endcase
      end else begin
        reject = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      blink_q <= '0;
      cmd_cnt <= '0;
      err_cnt <= '0;
    end else begin
      level_q <= level_d;
      blink_q <= blink_d;
      if (accept) cmd_cnt <= cmd_cnt + CNT_ONE;
      if (reject && err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
    end
  end

  ntr_blink_timer #(
    .PRESCALE (PRESCALE)
  ) u_blink (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (period_load),
    .load_period (f_arg[15:1]),
    .phase       (phase)
  );

  assign leds = level_q & (~blink_q | {CHANNELS{phase}});

endmodule
